// File: rtl/color_arbiter_pkg.sv
// Shared types and codes for the colour arbiter: shadow colour, controller
// states, command codes and the Color FSM output encodings.
package color_pkg;

  typedef enum logic {
    BLUE = 1'h0,
    RED  = 1'h1
  } Color_state;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE
  } CtrlState;

  localparam logic [1:0] CMD_HOLD   = 2'h0;
  localparam logic [1:0] CMD_TOGGLE = 2'h1;

  localparam logic [1:0] OUT_BLUE = 2'h1;
  localparam logic [1:0] OUT_RED  = 2'h2;

endpackage

// File: rtl/color_arbiter_if.sv
// Requester handshake plus the shared Color FSM connection; the arbiter
// takes the slave view, the requester/FSM side takes the master view.
interface color_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_cmd;
  logic [NUM_REQ-1:0]   req_ready;
  logic [1:0]           fsm_in;
  logic [1:0]           fsm_out;
  logic [IDX_W-1:0]     grant_id;
  logic                 busy;
  logic                 color;
  logic                 color_err;

  modport master (
    output req_valid, req_cmd, fsm_out,
    input  req_ready, fsm_in, grant_id, busy, color, color_err
  );

  modport slave (
    input  req_valid, req_cmd, fsm_out,
    output req_ready, fsm_in, grant_id, busy, color, color_err
  );
endinterface

// File: rtl/color_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping past the top index.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               slot;
  logic [IDX_W-1:0] slotIdx;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    slot    = 0;
    slotIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(ptr_i) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      slotIdx = IDX_W'(slot);
      if (!found && req_i[slotIdx]) begin
        found            = 1'b1;
        grant_o[slotIdx] = 1'b1;
        idx_o            = slotIdx;
      end
    end
  end

endmodule

// File: rtl/color_arbiter.sv
// Round-robin sequencer for a shared two-state Color FSM: issues one command
// per grant, waits out a settle window, and checks the FSM against a shadow.
module color_arbiter
  import color_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  color_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  CtrlState         state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grantId_q;
  logic [1:0]       fsmIn_q;
  logic             busy_q;
  Color_state       color_q;
  logic             colorErr_q;
  logic [CNT_W-1:0] settleCnt_q;

  logic [NUM_REQ-1:0] winOneHot;
  logic [IDX_W-1:0]   winIdx;
  logic [IDX_W-1:0]   ptr_d;
  logic [1:0]         selCmd;
  logic [1:0]         fsmOutExp;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i  (bus.req_valid),
    .ptr_i  (ptr_q),
    .grant_o(winOneHot),
    .idx_o  (winIdx)
  );

  assign ptr_d     = (winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
  assign selCmd    = bus.req_cmd[{winIdx, 1'b0} +: 2];
  assign fsmOutExp = (color_q == RED) ? OUT_RED : OUT_BLUE;

  // Ready is the only combinational output; it is gated by reset so nothing
  // is accepted while the block is held.
  assign bus.req_ready = (rst && state_q == IDLE) ? winOneHot : '0;
  assign bus.fsm_in    = fsmIn_q;
  assign bus.grant_id  = grantId_q;
  assign bus.busy      = busy_q;
  assign bus.color     = color_q;
  assign bus.color_err = colorErr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grantId_q   <= '0;
      fsmIn_q     <= CMD_HOLD;
      busy_q      <= 1'b0;
      color_q     <= RED;
      colorErr_q  <= 1'b0;
      settleCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The FSM is only compared while idle, so settle transients never flag.
          if (bus.fsm_out != fsmOutExp) colorErr_q <= 1'b1;
          if (|bus.req_valid) begin
            fsmIn_q   <= selCmd;
            grantId_q <= winIdx;
            ptr_q     <= ptr_d;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (fsmIn_q == CMD_TOGGLE) color_q <= (color_q == RED) ? BLUE : RED;
          fsmIn_q     <= CMD_HOLD;
          settleCnt_q <= CNT_W'(HOLD_CYCLES - 1);
          state_q     <= SETTLE;
        end
        SETTLE: begin
          if (settleCnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            settleCnt_q <= settleCnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
